// File: rtl/int_controller_v2.sv
// Interrupt controller: synchronises hardware/timer lines, keeps ESTAT.IS pending state,
// prioritises enabled sources and handshakes with WB. Optional SWI registers via INTC_SWI_EN.
module int_controller_v2 #(
  parameter int         N_EXT       = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] EDGE_MASK   = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EXT-1:0] ext_irq,
  input  logic             timer_irq,
  input  logic [N_EXT-1:0] ext_clr,
  input  logic             ti_clr,
  input  logic [1:0]       swi_set,
  input  logic [1:0]       swi_clr,
  input  logic             mie,
  input  logic [12:0]      ecfg_lie,
  output logic [12:0]      estat_is,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic             int_ack,
  input  logic             ertn,
  input  logic             in_exception,
  output logic             int_req,
  output logic [5:0]       int_cause,
  output logic [31:0]      int_pc
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t state, state_nxt;

  logic [N_EXT-1:0]       ext_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] tmr_sync;
  logic [N_EXT-1:0]       ext_synced, ext_prev, ext_rise;
  logic                   tmr_synced, tmr_prev, tmr_rise;
  logic [N_EXT-1:0]       hwi_pend;
  logic                   timer_pend;
  logic [1:0]             swi_pend;
  logic [12:0]            is_vec, enabled;
  logic                   any_en;
  logic [5:0]             sel;
  logic                   req_nxt;
  logic [5:0]             cause_nxt;
  logic [31:0]            pc_nxt;

  // The extra "prev" flop after the synchroniser gives a clean one-cycle rise detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) ext_sync[i] <= '0;
      tmr_sync <= '0;
      ext_prev <= '0;
      tmr_prev <= 1'b0;
    end else begin
      ext_sync[0] <= ext_irq;
      tmr_sync[0] <= timer_irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ext_sync[i] <= ext_sync[i-1];
        tmr_sync[i] <= tmr_sync[i-1];
      end
      ext_prev <= ext_synced;
      tmr_prev <= tmr_synced;
    end
  end

  assign ext_synced = ext_sync[SYNC_STAGES-1];
  assign tmr_synced = tmr_sync[SYNC_STAGES-1];
  assign ext_rise   = ext_synced & ~ext_prev;
  assign tmr_rise   = tmr_synced & ~tmr_prev;

  // Edge lines latch until a CSR clear (set wins); level lines simply mirror the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwi_pend   <= '0;
      timer_pend <= 1'b0;
    end else begin
      for (int i = 0; i < N_EXT; i++) begin
        if (EDGE_MASK[i]) hwi_pend[i] <= ext_rise[i] | (hwi_pend[i] & ~ext_clr[i]);
        else              hwi_pend[i] <= ext_synced[i];
      end
      timer_pend <= tmr_rise | (timer_pend & ~ti_clr);
    end
  end

`ifdef INTC_SWI_EN
  always_ff @(posedge clk) begin
    if (rst) swi_pend <= 2'b00;
    else     swi_pend <= swi_set | (swi_pend & ~swi_clr);
  end
`else
  logic unused_swi;
  assign swi_pend   = 2'b00;
  assign unused_swi = ^{swi_set, swi_clr};
`endif

  always_comb begin
    is_vec            = '0;
    is_vec[1:0]       = swi_pend;
    is_vec[2 +: N_EXT] = hwi_pend;
    is_vec[11]        = timer_pend;
  end

  assign estat_is = is_vec;
  assign enabled  = is_vec & ecfg_lie;
  assign any_en   = |enabled;

  // Ascending scan so the highest enabled index is the last one written.
  always_comb begin
    sel = '0;
    for (int i = 0; i < 13; i++) begin
      if (enabled[i]) sel = 6'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      int_req   <= 1'b0;
      int_cause <= '0;
      int_pc    <= '0;
    end else begin
      state     <= state_nxt;
      int_req   <= req_nxt;
      int_cause <= cause_nxt;
      int_pc    <= pc_nxt;
    end
  end

  // Acceptance takes precedence over withdrawal; the cause freezes once accepted.
  always_comb begin
    state_nxt = state;
    req_nxt   = int_req;
    cause_nxt = int_cause;
    pc_nxt    = int_pc;
    case (state)
      IDLE: begin
        if (mie && any_en && !in_exception) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          cause_nxt = sel;
        end
      end
      REQ: begin
        if (int_ack && wb_valid) begin
          state_nxt = SERVICE;
          req_nxt   = 1'b0;
          pc_nxt    = wb_pc;
        end else if (!mie || !any_en || in_exception) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end else begin
          cause_nxt = sel;
        end
      end
      SERVICE: begin
        req_nxt = 1'b0;
        if (ertn) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_int_controller_v2.sv
// Bench for int_controller_v2: directed scenarios plus randomized traffic against a cycle model.
module tb_int_controller_v2;

  localparam int         S     = 2;
  localparam logic [7:0] EMASK = 8'hFE;
`ifdef INTC_SWI_EN
  localparam bit SWI_EN = 1'b1;
`else
  localparam bit SWI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ext_irq = '0;
  logic        timer_irq = 1'b0;
  logic [7:0]  ext_clr = '0;
  logic        ti_clr = 1'b0;
  logic [1:0]  swi_set = '0;
  logic [1:0]  swi_clr = '0;
  logic        mie = 1'b0;
  logic [12:0] ecfg_lie = '0;
  logic [12:0] estat_is;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        int_ack = 1'b0;
  logic        ertn = 1'b0;
  logic        in_exception = 1'b0;
  logic        int_req;
  logic [5:0]  int_cause;
  logic [31:0] int_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  int_controller_v2 #(.N_EXT(8), .SYNC_STAGES(S), .EDGE_MASK(EMASK)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .timer_irq(timer_irq),
    .ext_clr(ext_clr), .ti_clr(ti_clr), .swi_set(swi_set), .swi_clr(swi_clr),
    .mie(mie), .ecfg_lie(ecfg_lie), .estat_is(estat_is), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .int_ack(int_ack), .ertn(ertn), .in_exception(in_exception),
    .int_req(int_req), .int_cause(int_cause), .int_pc(int_pc)
  );

  // Reference model: input history per edge, pending bits and a requesting/servicing pair.
  logic [7:0]  h_ext [0:S];
  logic        h_tmr [0:S];
  logic [7:0]  m_hwi;
  logic        m_tmr;
  logic [1:0]  m_swi;
  logic        m_req, m_svc;
  logic [5:0]  m_cause;
  logic [31:0] m_pc;

  function automatic logic [12:0] m_is();
    return {1'b0, m_tmr, 1'b0, m_hwi, m_swi};
  endfunction

  task automatic tick();
    logic [12:0] en;
    logic [5:0]  top;
    logic [7:0]  sy, pv;
    logic        nreq, nsvc;
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j <= S; j++) begin h_ext[j] = '0; h_tmr[j] = 1'b0; end
      m_hwi = '0; m_tmr = 1'b0; m_swi = '0;
      m_req = 1'b0; m_svc = 1'b0; m_cause = '0; m_pc = '0;
    end else begin
      en  = m_is() & ecfg_lie;
      top = '0;
      for (int i = 12; i >= 0; i--) if (en[i]) begin top = 6'(i); break; end
      nreq = m_req; nsvc = m_svc;
      if (!m_req && !m_svc) begin
        if (mie && en != 0 && !in_exception) begin nreq = 1'b1; m_cause = top; end
      end else if (m_req) begin
        if (int_ack && wb_valid) begin nreq = 1'b0; nsvc = 1'b1; m_pc = wb_pc; end
        else if (!mie || en == 0 || in_exception) nreq = 1'b0;
        else m_cause = top;
      end else if (ertn) begin
        nsvc = 1'b0;
      end
      m_req = nreq; m_svc = nsvc;
      sy = h_ext[S-1]; pv = h_ext[S];
      for (int i = 0; i < 8; i++) begin
        if (!EMASK[i])             m_hwi[i] = sy[i];
        else if (sy[i] && !pv[i])  m_hwi[i] = 1'b1;
        else if (ext_clr[i])       m_hwi[i] = 1'b0;
      end
      if (h_tmr[S-1] && !h_tmr[S]) m_tmr = 1'b1;
      else if (ti_clr)             m_tmr = 1'b0;
      if (SWI_EN) begin
        for (int j = 0; j < 2; j++) begin
          if (swi_set[j])      m_swi[j] = 1'b1;
          else if (swi_clr[j]) m_swi[j] = 1'b0;
        end
      end
      for (int j = S; j > 0; j--) begin h_ext[j] = h_ext[j-1]; h_tmr[j] = h_tmr[j-1]; end
      h_ext[0] = ext_irq;
      h_tmr[0] = timer_irq;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (estat_is !== 13'h0) begin n_bad++; $display("[TB] FAIL reset_is: got %h want 0", estat_is); end
    n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_req: got %b want 0", int_req); end
    n_cmp++; if (int_cause !== 6'd0) begin n_bad++; $display("[TB] FAIL reset_cause: got %0d want 0", int_cause); end
    n_cmp++; if (int_pc !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_pc: got %h want 0", int_pc); end
  endtask

  task automatic test_edge_latch();
    ecfg_lie = 13'h1FFC; mie = 1'b1;
    ext_irq = 8'h08; tick(); ext_irq = 8'h00; tick();
    n_cmp++; if (estat_is !== 13'h0) begin n_bad++; $display("[TB] FAIL edge_early: got %h want 0", estat_is); end
    tick();
    n_cmp++; if (estat_is !== 13'h0020) begin n_bad++; $display("[TB] FAIL edge_is: got %h want 0020", estat_is); end
    n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("[TB] FAIL edge_req_early: got %b want 0", int_req); end
    tick();
    n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("[TB] FAIL edge_req: got %b want 1", int_req); end
    n_cmp++; if (int_cause !== 6'd5) begin n_bad++; $display("[TB] FAIL edge_cause: got %0d want 5", int_cause); end
    ext_clr = 8'h08; tick(); ext_clr = 8'h00;
    n_cmp++; if (estat_is !== 13'h0) begin n_bad++; $display("[TB] FAIL edge_clr: got %h want 0", estat_is); end
    tick();
    n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("[TB] FAIL edge_req_drop: got %b want 0", int_req); end
  endtask

  task automatic test_priority();
    logic [31:0] pc;
    pc = $urandom & 32'hFFFF_FFFC;
    timer_irq = 1'b1; ext_irq = 8'h80; tick();
    timer_irq = 1'b0; ext_irq = 8'h00; tick(); tick();
    n_cmp++; if (estat_is !== 13'h0A00) begin n_bad++; $display("[TB] FAIL prio_is: got %h want 0A00", estat_is); end
    tick();
    n_cmp++; if (int_cause !== 6'd11) begin n_bad++; $display("[TB] FAIL prio_cause: got %0d want 11", int_cause); end
    int_ack = 1'b1; wb_valid = 1'b1; wb_pc = pc; tick(); int_ack = 1'b0; wb_valid = 1'b0;
    n_cmp++; if (int_pc !== pc) begin n_bad++; $display("[TB] FAIL prio_pc: got %h want %h", int_pc, pc); end
    ti_clr = 1'b1; ertn = 1'b1; tick(); ti_clr = 1'b0; ertn = 1'b0;
    n_cmp++; if (estat_is !== 13'h0200) begin n_bad++; $display("[TB] FAIL prio_ticlr: got %h want 0200", estat_is); end
    tick();
    n_cmp++; if (int_req !== 1'b1 || int_cause !== 6'd9) begin n_bad++; $display("[TB] FAIL prio_rereq: got req=%b cause=%0d want req=1 cause=9", int_req, int_cause); end
  endtask

  task automatic test_handshake();
    int_ack = 1'b1; wb_valid = 1'b0; tick();
    n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("[TB] FAIL hs_novalid: got %b want 1", int_req); end
    wb_valid = 1'b1; wb_pc = 32'h1C00_0040; tick(); int_ack = 1'b0; wb_valid = 1'b0;
    n_cmp++; if (int_pc !== 32'h1C00_0040) begin n_bad++; $display("[TB] FAIL hs_pc: got %h want 1c000040", int_pc); end
    n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("[TB] FAIL hs_req_low: got %b want 0", int_req); end
    ertn = 1'b1; tick(); ertn = 1'b0;
    n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("[TB] FAIL hs_ertn: got %b want 0", int_req); end
    tick();
    n_cmp++; if (int_req !== 1'b1 || int_cause !== 6'd9) begin n_bad++; $display("[TB] FAIL hs_rereq: got req=%b cause=%0d want req=1 cause=9", int_req, int_cause); end
    ext_clr = 8'h80; tick(); ext_clr = 8'h00; tick();
    n_cmp++; if (int_req !== 1'b0 || estat_is !== 13'h0) begin n_bad++; $display("[TB] FAIL hs_cleanup: got req=%b is=%h want req=0 is=0", int_req, estat_is); end
  endtask

  task automatic test_level();
    ext_irq = 8'h01; tick(); tick(); tick();
    n_cmp++; if (estat_is !== 13'h0004) begin n_bad++; $display("[TB] FAIL lvl_set: got %h want 0004", estat_is); end
    ext_clr = 8'h01; tick(); ext_clr = 8'h00;
    n_cmp++; if (estat_is !== 13'h0004) begin n_bad++; $display("[TB] FAIL lvl_clr_ignored: got %h want 0004", estat_is); end
    n_cmp++; if (int_req !== 1'b1 || int_cause !== 6'd2) begin n_bad++; $display("[TB] FAIL lvl_req: got req=%b cause=%0d want req=1 cause=2", int_req, int_cause); end
    ext_irq = 8'h00; tick(); tick();
    n_cmp++; if (estat_is !== 13'h0004) begin n_bad++; $display("[TB] FAIL lvl_hold: got %h want 0004", estat_is); end
    tick();
    n_cmp++; if (estat_is !== 13'h0) begin n_bad++; $display("[TB] FAIL lvl_fall: got %h want 0", estat_is); end
    tick();
    n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("[TB] FAIL lvl_req_drop: got %b want 0", int_req); end
  endtask

  task automatic test_masking();
    mie = 1'b0; ext_irq = 8'h04; tick(); ext_irq = 8'h00; tick(); tick(); tick(); tick();
    n_cmp++; if (estat_is !== 13'h0010 || int_req !== 1'b0) begin n_bad++; $display("[TB] FAIL mask_hold: got is=%h req=%b want is=0010 req=0", estat_is, int_req); end
    mie = 1'b1; tick();
    n_cmp++; if (int_req !== 1'b1 || int_cause !== 6'd4) begin n_bad++; $display("[TB] FAIL mask_enable: got req=%b cause=%0d want req=1 cause=4", int_req, int_cause); end
    in_exception = 1'b1; tick();
    n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("[TB] FAIL mask_inexc: got %b want 0", int_req); end
    in_exception = 1'b0; tick();
    n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("[TB] FAIL mask_resume: got %b want 1", int_req); end
    ext_clr = 8'h04; tick(); ext_clr = 8'h00; tick();
  endtask

  task automatic test_reset_mid_swi();
    ext_irq = 8'h10; tick(); ext_irq = 8'h00; tick(); tick(); tick();
    int_ack = 1'b1; wb_valid = 1'b1; wb_pc = 32'hDEAD_BEE0; tick(); int_ack = 1'b0; wb_valid = 1'b0;
    n_cmp++; if (int_pc !== 32'hDEAD_BEE0) begin n_bad++; $display("[TB] FAIL rst_svc_pc: got %h want deadbee0", int_pc); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (estat_is !== 13'h0 || int_pc !== 32'h0 || int_req !== 1'b0 || int_cause !== 6'd0) begin
      n_bad++; $display("[TB] FAIL rst_mid: got is=%h pc=%h req=%b cause=%0d want all 0", estat_is, int_pc, int_req, int_cause);
    end
    ecfg_lie = 13'h1FFF; swi_set = 2'b10; tick(); swi_set = 2'b00;
    n_cmp++; if (estat_is !== (SWI_EN ? 13'h0002 : 13'h0)) begin n_bad++; $display("[TB] FAIL swi_is: got %h want %h", estat_is, SWI_EN ? 13'h0002 : 13'h0); end
    tick();
    n_cmp++; if (int_req !== SWI_EN || int_cause !== (SWI_EN ? 6'd1 : 6'd0)) begin
      n_bad++; $display("[TB] FAIL swi_req: got req=%b cause=%0d want req=%b", int_req, int_cause, SWI_EN);
    end
    swi_clr = 2'b10; tick(); swi_clr = 2'b00; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      ext_irq      = ext_irq ^ (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
      timer_irq    = ($urandom_range(0, 5) == 0);
      ext_clr      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ti_clr       = ($urandom_range(0, 4) == 0);
      swi_set      = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      swi_clr      = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      mie          = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) ecfg_lie = 13'($urandom);
      int_ack      = $urandom_range(0, 1) == 1;
      wb_valid     = $urandom_range(0, 1) == 1;
      wb_pc        = $urandom;
      ertn         = ($urandom_range(0, 5) == 0);
      in_exception = ($urandom_range(0, 9) == 0);
      tick();
      n_cmp++; if (estat_is !== m_is()) begin n_bad++; $display("[TB] FAIL rnd_is c=%0d: got %h want %h", c, estat_is, m_is()); end
      n_cmp++; if (int_req !== m_req) begin n_bad++; $display("[TB] FAIL rnd_req c=%0d: got %b want %b", c, int_req, m_req); end
      n_cmp++; if (int_cause !== m_cause) begin n_bad++; $display("[TB] FAIL rnd_cause c=%0d: got %0d want %0d", c, int_cause, m_cause); end
      n_cmp++; if (int_pc !== m_pc) begin n_bad++; $display("[TB] FAIL rnd_pc c=%0d: got %h want %h", c, int_pc, m_pc); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_latch();
    test_priority();
    test_handshake();
    test_level();
    test_masking();
    test_reset_mid_swi();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_controller_v2.md
Name: int_controller_v2

Overview:
Parametrised successor interrupt controller for the 5-stage LoongArch-style core.
- Synchronises N_EXT hardware lines plus the timer line, with per-channel edge or level capture.
- Maintains the 13-bit ESTAT.IS pending vector, masks it with ECFG.LIE and CRMD.IE, and priority-encodes the winner.
- Runs a request/acknowledge/service FSM towards the WB stage.
- Pending state survives pipeline flushes; it is cleared only by explicit CSR-driven clears.

Parameters:
N_EXT, 8, number of hardware interrupt lines (1..8); they map to IS bits [2+N_EXT-1:2].
SYNC_STAGES, 2, synchroniser depth on every async input (1..3).
EDGE_MASK, 8'hFF, per-line capture mode: bit i=1 is rising-edge latched, bit i=0 is level (follows the synchronised line).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ext_irq  in  N_EXT  asynchronous hardware interrupt lines
timer_irq  in  1  asynchronous timer expiry pulse/level (edge captured)
ext_clr  in  N_EXT  one-cycle clear of edge-latched pending bits (CSR write)
ti_clr  in  1  one-cycle clear of timer pending (TICLR write)
swi_set  in  2  software interrupt set (used only with INTC_SWI_EN)
swi_clr  in  2  software interrupt clear (used only with INTC_SWI_EN)
mie  in  1  global interrupt enable (CRMD.IE)
ecfg_lie  in  13  local enables (ECFG.LIE)
estat_is  out  13  pending vector (ESTAT.IS)
wb_valid  in  1  WB stage holds a valid instruction
wb_pc  in  32  WB stage PC
int_ack  in  1  WB accepts the interrupt this cycle
ertn  in  1  exception return retiring
in_exception  in  1  core in exception handler (other source)
int_req  out  1  interrupt request to WB
int_cause  out  6  IS bit index of the granted source
int_pc  out  32  PC captured at acceptance

Behaviour:
- Reset (rst=1 at a clk edge): all synchroniser flops, pending bits, previous-sample flops, FSM=IDLE, int_req=0, int_cause=0, int_pc=0, estat_is=0.
- Sync: each async input passes through SYNC_STAGES flops. Rise = synced & ~prev_synced, where prev is one further flop.
- Edge line i: pending set on rise, cleared on ext_clr[i]; set wins over a simultaneous clear.
- Level line i: pending register <= synced value each cycle; ext_clr[i] has no effect.
- Timer: edge-captured into IS[11], cleared by ti_clr; set wins.
- Layout: IS[1:0]=SWI, IS[2+N_EXT-1:2]=HWI, IS[11]=timer. IS[12] and unused HWI bits read 0.
- Latency (SYNC_STAGES=2): line rises before edge k → estat_is bit set after edge k+2 → int_req high after edge k+3.
- enabled = estat_is & ecfg_lie. Priority: highest set index wins (11 > 9 > ... > 2 > 1 > 0). sel = that index.
- FSM:
  - IDLE: if mie & |enabled & ~in_exception → REQ; int_req<=1, int_cause<=sel.
  - REQ: int_req held high; int_cause tracks sel each cycle.
    - If int_ack & wb_valid → SERVICE; int_pc<=wb_pc, int_req<=0, int_cause frozen.
    - Else if ~mie | ~|enabled | in_exception → IDLE, int_req<=0.
  - SERVICE: int_req=0. On ertn → IDLE. New pending bits still accumulate.
  - int_ack outside REQ, or without wb_valid, is ignored.
- flush has no effect on pending or FSM.
- rst mid-REQ or mid-SERVICE returns the block to IDLE next edge with all outputs cleared.

Optional Feature:
INTC_SWI_EN
- Defined: IS[1:0] are registers. swi_set[j] sets bit j, swi_clr[j] clears it; set wins over a simultaneous clear. No synchroniser; the bit is visible in estat_is the cycle after the set.
- Undefined: IS[1:0] are constant 0; swi_set/swi_clr are ignored.

Test Plan:
- Edge latch: N_EXT=8, ext_irq[3] 0→1 for 1 cycle, lie=13'h1FFC, mie=1 → estat_is=13'h0020 after 2 edges, int_req=1 one edge later, int_cause=5; ext_clr[3] → bit clears.
- Priority: timer pulse and ext_irq[7] rise in the same cycle → estat_is=13'h0A00, int_cause=11; after ti_clr and ertn, a re-request gives int_cause=9.
- Handshake: in REQ, int_ack=1 with wb_valid=0 → stays in REQ; then int_ack=1, wb_valid=1, wb_pc=32'h1C00_0040 → int_pc=32'h1C00_0040, int_req=0; ertn → IDLE, and int_req re-asserts while the pending bit remains.
- Level mode: EDGE_MASK=8'hFE, ext_irq[0] held high → IS[2]=1; ext_clr[0] has no effect; line low → IS[2]=0 after 2 edges; if in REQ with no other sources, int_req drops.
- Flush and masking: pending IS[4] with mie=0 → int_req stays 0 and IS[4] is retained; mie→1 → int_req=1; in_exception=1 while in REQ → IDLE.
- Reset mid-SERVICE and SWI (INTC_SWI_EN): rst=1 for one edge → estat_is=0, int_pc=0, FSM IDLE; swi_set=2'b10 → estat_is=13'h0002 next cycle, int_cause=1 when lie[1]=1.
